serial_eq_cmp: RTL and testbench
================================

SERIAL_EQ_CMP -- requirements
Module: serial_eq_cmp

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of bit pairs per compared word (legal range 2..64).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to begin a new word comparison.
REQ-005 SHALL have port bit_valid, input, 1, qualifier meaning a and b carry a valid bit pair this cycle.
REQ-006 SHALL have port a, input, 1, serial bit of word A, LSB first.
REQ-007 SHALL have port b, input, 1, serial bit of word B, LSB first.
REQ-008 SHALL have port busy, output, 1, high while a comparison is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when a word comparison completes.
REQ-010 SHALL have port eq, output, 1, registered result: 1 when all WIDTH bit pairs matched.
REQ-011 SHALL have port mism, output, $clog2(WIDTH+1), count of mismatching bit pairs in the last word.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN, DONE.
REQ-013 SHALL, in IDLE or DONE with start=1, go to RUN next cycle, clearing bit counter to 0, setting the equality accumulator to 1, and clearing the mismatch accumulator.
REQ-014 SHALL, in RUN, ignore start.
REQ-015 SHALL, in RUN with bit_valid=1, compute per-bit match = a XNOR b, AND it into the equality accumulator, add !match to the mismatch accumulator, and increment the bit counter.
REQ-016 SHALL, in RUN with bit_valid=0, hold all accumulators and the counter (stall, no bit consumed).
REQ-017 SHALL, when the bit counter equals WIDTH-1 and bit_valid=1 in RUN, go to DONE and load eq and mism with the final accumulator values including that last bit.
REQ-018 SHALL assert done for exactly the one cycle the FSM is in DONE, then return to IDLE unless start=1.
REQ-019 SHALL hold eq and mism stable from DONE until the next completed comparison; they are not cleared by start.
REQ-020 SHALL assert busy exactly in RUN; busy and done are never high together.
REQ-021 SHALL ignore bit_valid, a and b in IDLE and DONE.
REQ-022 SHALL keep the bit counter at its minimum width $clog2(WIDTH) with no wrap beyond WIDTH-1.
REQ-023 SHALL give a latency of WIDTH valid bit cycles plus one cycle from start acceptance to done, with no stalls: start at cycle 0, done at cycle WIDTH+1.

Reset
REQ-024 SHALL, on rst_n=0 at any time including mid-RUN, immediately force state IDLE, counter 0, busy=0, done=0, eq=0, mism=0, discarding any partial word.
REQ-025 SHALL resume normal operation on the first rising clk edge after rst_n returns high.

Configuration
REQ-026 SHALL use macro SERIAL_EQ_CMP_COUNT_EN to include the mismatch accumulator.
REQ-027 SHALL, with SERIAL_EQ_CMP_COUNT_EN defined, drive mism as in REQ-015/017.
REQ-028 SHALL, without SERIAL_EQ_CMP_COUNT_EN, omit the mismatch accumulator, keep port mism, and tie it to 0; all other behaviour is unchanged.

Verification (WIDTH=8, SERIAL_EQ_CMP_COUNT_EN defined unless noted)
REQ-029 SHALL cover: start, then 8 valid pairs A=B=8'hA5 -> done pulse at cycle 9, eq=1, mism=0.
REQ-030 SHALL cover: A=8'h00, B=8'hFF with no stalls -> eq=0, mism=8.
REQ-031 SHALL cover: A=8'h5A, B=8'h5B with bit_valid=0 inserted for 3 cycles after bit 2 -> done at cycle 12, eq=0, mism=1.
REQ-032 SHALL cover: rst_n pulsed low after 4 bits -> busy=0, eq=0, mism=0 at once; no done pulse; a subsequent full equal word yields eq=1.
REQ-033 SHALL cover: start held high throughout RUN and on the done cycle -> start ignored in RUN, new comparison begins directly from DONE, and eq holds the previous result until the new done.
REQ-034 SHALL cover: build without SERIAL_EQ_CMP_COUNT_EN, A=8'h00, B=8'hFF -> eq=0, mism=0.

Source files
------------

// File: rtl/serial_eq_cmp.sv
// rtl/serial_eq_cmp.sv - bit-serial word equality comparator, LSB first
// Optional mismatch counter enabled by defining SERIAL_EQ_CMP_COUNT_EN.
module serial_eq_cmp #(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         bit_valid,
  input  logic                         a,
  input  logic                         b,
  output logic                         busy,
  output logic                         done,
  output logic                         eq,
  output logic [$clog2(WIDTH+1)-1:0]   mism
);

  localparam int CW = $clog2(WIDTH);
  localparam int MW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          eq_acc;
  logic          eq_q;
  logic          match;
  logic          take;
  logic          last;
  logic          accept;

  assign match  = ~(a ^ b);
  assign take   = (state == S_RUN) && bit_valid;
  assign last   = take && (cnt == LAST);
  // start is only honoured between words; while running it is ignored
  assign accept = ((state == S_IDLE) || (state == S_DONE)) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      eq_acc <= 1'b0;
      eq_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state  <= S_RUN;
            cnt    <= '0;
            eq_acc <= 1'b1;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_RUN: begin
          if (last) begin
            state <= S_DONE;
            eq_q  <= eq_acc & match;
          end else if (take) begin
            cnt    <= cnt + 1'b1;
            eq_acc <= eq_acc & match;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SERIAL_EQ_CMP_COUNT_EN
  logic [MW-1:0] mis_acc;
  logic [MW-1:0] mism_q;
  logic [MW-1:0] mis_next;

  assign mis_next = mis_acc + MW'(~match);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_acc <= '0;
      mism_q  <= '0;
    end else if (accept) begin
      mis_acc <= '0;
    end else if (last) begin
      mism_q  <= mis_next;
    end else if (take) begin
      mis_acc <= mis_next;
    end
  end

  assign mism = mism_q;
`else
  assign mism = '0;
`endif

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);
  assign eq   = eq_q;

endmodule

// File: tb/tb_serial_eq_cmp.sv
// tb/tb_serial_eq_cmp.sv - randomized self-checking bench for serial_eq_cmp
module tb_serial_eq_cmp;

  localparam int W  = 8;
  localparam int MW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n, start, bit_valid, a, b;
  logic          busy, done, eq;
  logic [MW-1:0] mism;

  int checks = 0;
  int errors = 0;

  logic          ref_eq;
  logic [MW-1:0] ref_mism;

  serial_eq_cmp #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
    .a(a), .b(b), .busy(busy), .done(done), .eq(eq), .mism(mism)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MW-1:0] model_mism(input logic [W-1:0] aw, input logic [W-1:0] bw);
`ifdef SERIAL_EQ_CMP_COUNT_EN
    return MW'($countones(aw ^ bw));
`else
    return '0;
`endif
  endfunction

  task automatic check_idle(input string tag);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || eq !== ref_eq || mism !== ref_mism) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b eq=%b mism=%0d, required busy=0 done=0 eq=%b mism=%0d",
               tag, busy, done, eq, mism, ref_eq, ref_mism);
    end
  endtask

  // Caller has just accepted start (cycle 0 edge done); we are in cycle 1.
  task automatic feed_word(input string tag, input logic [W-1:0] aw, input logic [W-1:0] bw,
                           input int stall_at, input int stall_len, input logic hold_start);
    int idx = 0;
    int stalls = stall_len;
    int cyc = 1;
    while (idx < W) begin
      start = hold_start ? 1'b1 : 1'($urandom);
      if (idx == stall_at && stalls > 0) begin
        bit_valid = 1'b0; a = 1'($urandom); b = 1'($urandom);
        stalls--;
      end else begin
        bit_valid = 1'b1; a = aw[idx]; b = bw[idx];
        idx++;
      end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || eq !== ref_eq || mism !== ref_mism) begin
        errors++;
        $display("FAIL %s run cyc %0d: busy=%b done=%b eq=%b mism=%0d, required busy=1 done=0 eq=%b mism=%0d",
                 tag, cyc, busy, done, eq, mism, ref_eq, ref_mism);
      end
      tick();
      cyc++;
    end
    ref_eq   = (aw == bw);
    ref_mism = model_mism(aw, bw);
    start     = hold_start;
    bit_valid = 1'($urandom);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || eq !== ref_eq || mism !== ref_mism) begin
      errors++;
      $display("FAIL %s done cyc %0d: done=%b busy=%b eq=%b mism=%0d, required done=1 busy=0 eq=%b mism=%0d",
               tag, W + 1 + stall_len, done, busy, eq, mism, ref_eq, ref_mism);
    end
  endtask

  task automatic run_word(input string tag, input logic [W-1:0] aw, input logic [W-1:0] bw,
                          input int stall_at, input int stall_len);
    start = 1'b1; bit_valid = 1'($urandom); a = 1'($urandom); b = 1'($urandom);
    tick();
    feed_word(tag, aw, bw, stall_at, stall_len, 1'b0);
    start = 1'b0;
    tick();
    check_idle({tag, " post"});
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; bit_valid = 1'b0; a = 1'b0; b = 1'b0;
    ref_eq = 1'b0; ref_mism = '0;
    tick(); tick();
    check_idle("reset");
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'($urandom); a = 1'($urandom); b = 1'($urandom);
      tick();
      check_idle("idle ignore");
    end
  endtask

  task automatic test_directed();
    run_word("eq_a5", 8'hA5, 8'hA5, -1, 0);
    run_word("ne_00_ff", 8'h00, 8'hFF, -1, 0);
    run_word("stall_5a_5b", 8'h5A, 8'h5B, 3, 3);
  endtask

  task automatic test_random();
    logic [W-1:0] aw, bw;
    for (int n = 0; n < 8; n++) begin
      aw = W'($urandom);
      bw = ($urandom_range(0, 2) == 0) ? aw : W'($urandom);
      run_word("random", aw, bw, $urandom_range(0, W), $urandom_range(0, 4));
    end
  endtask

  task automatic test_mid_reset();
    run_word("pre_reset", 8'h3C, 8'h3C, -1, 0);
    start = 1'b1; tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1; a = 1'($urandom); b = 1'($urandom);
      tick();
    end
    rst_n = 1'b0;
    #1;
    ref_eq = 1'b0; ref_mism = '0;
    check_idle("mid_reset async");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bit_valid = 1'($urandom); a = 1'($urandom); b = 1'($urandom);
      tick();
      check_idle("after reset no done");
    end
    run_word("post_reset_eq", 8'hC3, 8'hC3, -1, 0);
  endtask

  task automatic test_back_to_back();
    start = 1'b1; tick();
    feed_word("b2b first", 8'h12, 8'h13, -1, 0, 1'b1);
    tick();
    feed_word("b2b second", 8'h77, 8'h77, 2, 1, 1'b1);
    tick();
    feed_word("b2b third", 8'hF0, 8'h0F, -1, 0, 1'b0);
    start = 1'b0;
    tick();
    check_idle("b2b post");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
